// File: rtl/rob_dispatch_ctrl_pkg.sv
// Shared definitions for the ROB dispatch/recovery controller and its helpers.
package rob_dispatch_ctrl_pkg;

    localparam int ROB_NUM_DEF        = 64;
    localparam int ROB_SEL_DEF        = 6;
    localparam int RECOVER_CYCLES_DEF = 2;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } rob_state_e;

    // ROB_NUM is a power of two, so wrap is a mask.
    function automatic int unsigned rob_incr(input int unsigned ptr,
                                             input int unsigned inc,
                                             input int unsigned num);
        return (ptr + inc) & (num - 1);
    endfunction

endpackage

// File: rtl/rob_kill_mask_gen.sv
// Wrapping range-to-mask generator: sets bits start_i .. end_i-1 (mod NUM),
// empty when start_i == end_i. Also used by the RS flush logic.
module rob_kill_mask_gen
    import rob_dispatch_ctrl_pkg::*;
#(
    parameter int NUM = ROB_NUM_DEF,
    parameter int SEL = ROB_SEL_DEF
) (
    input  logic [SEL-1:0] start_i,
    input  logic [SEL-1:0] end_i,
    output logic [NUM-1:0] mask_o
);

    logic [SEL-1:0] len;

    always_comb begin
        mask_o = '0;
        len    = end_i - start_i;
        for (int i = 0; i < NUM; i++) begin
            mask_o[i] = SEL'(SEL'(i) - start_i) < len;
        end
    end

endmodule

// File: rtl/rob_dispatch_ctrl.sv
// ROB allocation controller: dual-slot grants, occupancy tracking, and
// mispredict rollback with a one-shot kill mask and a fixed recovery window.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_RUN     | normal dispatch; grants allowed
// ST_RECOVER | post-mispredict window; grants blocked, busy_o high
module rob_dispatch_ctrl
    import rob_dispatch_ctrl_pkg::*;
#(
    parameter int ROB_NUM        = ROB_NUM_DEF,
    parameter int ROB_SEL        = ROB_SEL_DEF,
    parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               req1_i,
    input  logic               req2_i,
    input  logic               stall_i,
    input  logic [1:0]         comnum_i,
    input  logic [ROB_SEL-1:0] commit_ptr_i,
    input  logic               prmiss_i,
    input  logic [ROB_SEL-1:0] prmiss_ptr_i,
    output logic               dp1_o,
    output logic               dp2_o,
    output logic [ROB_SEL-1:0] dp1_addr_o,
    output logic [ROB_SEL-1:0] dp2_addr_o,
    output logic [ROB_SEL-1:0] dispatch_ptr_o,
    output logic [ROB_SEL:0]   freenum_o,
    output logic               full_o,
    output logic [ROB_NUM-1:0] kill_vec_o,
    output logic               busy_o
);

    localparam int RC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RECOVER_CYCLES - 1);

    rob_state_e         state_q, state_d;
    logic [RC_W-1:0]    rcnt_q, rcnt_d;
    logic [ROB_SEL-1:0] ptr_q, ptr_d;
    logic [ROB_SEL:0]   cnt_q, cnt_d;
    logic [ROB_NUM-1:0] kill_q, kill_d;

    logic [ROB_SEL:0]   freenum;
    logic [1:0]         grant_n;
    logic [ROB_SEL-1:0] miss_start;
    logic [ROB_SEL-1:0] miss_span;
    logic [ROB_SEL:0]   miss_cnt;
    logic [ROB_NUM-1:0] miss_mask;

    assign freenum = (ROB_SEL+1)'(ROB_NUM) - cnt_q;

    // Grants see only registered occupancy; same-cycle commits free slots next cycle.
    assign dp1_o = reset_n_i & req1_i & ~stall_i & ~prmiss_i
                 & (state_q == ST_RUN) & (freenum != '0);
    assign dp2_o = dp1_o & req2_i & (freenum >= (ROB_SEL+1)'(2));

    assign grant_n    = 2'(dp1_o) + 2'(dp2_o);
    assign dp1_addr_o = ptr_q;
    assign dp2_addr_o = ROB_SEL'(rob_incr(32'(ptr_q), 32'd1, ROB_NUM));

    assign miss_start = ROB_SEL'(rob_incr(32'(prmiss_ptr_i), 32'd1, ROB_NUM));
    assign miss_span  = prmiss_ptr_i - commit_ptr_i;
    assign miss_cnt   = {1'b0, miss_span} + (ROB_SEL+1)'(1) - (ROB_SEL+1)'(comnum_i);

    rob_kill_mask_gen #(
        .NUM (ROB_NUM),
        .SEL (ROB_SEL)
    ) u_kill_mask (
        .start_i (miss_start),
        .end_i   (ptr_q),
        .mask_o  (miss_mask)
    );

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        ptr_d   = ROB_SEL'(rob_incr(32'(ptr_q), 32'(grant_n), ROB_NUM));
        cnt_d   = cnt_q + (ROB_SEL+1)'(grant_n) - (ROB_SEL+1)'(comnum_i);
        kill_d  = '0;
        if (prmiss_i) begin
            state_d = ST_RECOVER;
            rcnt_d  = RC_LOAD;
            ptr_d   = miss_start;
            cnt_d   = miss_cnt;
            kill_d  = miss_mask;
        end else if (state_q == ST_RECOVER) begin
            if (rcnt_q == '0) begin
                state_d = ST_RUN;
            end else begin
                rcnt_d = rcnt_q - RC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= ST_RUN;
            rcnt_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            kill_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
        end
    end

    assign dispatch_ptr_o = ptr_q;
    assign freenum_o      = freenum;
    assign full_o         = (freenum == '0);
    assign kill_vec_o     = kill_q;
    assign busy_o         = (state_q == ST_RECOVER);

    // Committing more than is occupied is a protocol error upstream.
    a_comnum_le_count: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (comnum_i <= 2'd2) && ((ROB_SEL+1)'(comnum_i) <= cnt_q));

endmodule

// File: tb/tb_rob_dispatch_ctrl.sv
// Directed bench for rob_dispatch_ctrl with an occupancy-level reference model.
module tb_rob_dispatch_ctrl;

    localparam int NUM = 64;
    localparam int RC  = 2;

    logic        clk = 1'b0;
    logic        reset_n, req1, req2, stall, prmiss;
    logic [1:0]  comnum;
    logic [5:0]  commit_ptr, prmiss_ptr;
    logic        dp1, dp2, full, busy;
    logic [5:0]  dp1_addr, dp2_addr, dispatch_ptr;
    logic [6:0]  freenum;
    logic [63:0] kill_vec;

    always #5 clk = ~clk;

    rob_dispatch_ctrl dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .req1_i         (req1),
        .req2_i         (req2),
        .stall_i        (stall),
        .comnum_i       (comnum),
        .commit_ptr_i   (commit_ptr),
        .prmiss_i       (prmiss),
        .prmiss_ptr_i   (prmiss_ptr),
        .dp1_o          (dp1),
        .dp2_o          (dp2),
        .dp1_addr_o     (dp1_addr),
        .dp2_addr_o     (dp2_addr),
        .dispatch_ptr_o (dispatch_ptr),
        .freenum_o      (freenum),
        .full_o         (full),
        .kill_vec_o     (kill_vec),
        .busy_o         (busy)
    );

    int errors = 0;
    int checks = 0;

    // Model: allocation pointer, occupancy, remaining busy cycles, pending kill.
    int          m_ptr, m_cnt, m_busy;
    logic [63:0] m_kill;

    logic        s_dp1, s_dp2;
    logic [5:0]  s_a1, s_a2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic r1, input logic r2, input logic st,
                        input int cn, input int cp, input logic pm, input int pp);
        int          free, n_ptr, n_cnt, n_busy, j;
        logic        g1, g2;
        logic [63:0] n_kill;
        reset_n    = rst;
        req1       = r1;
        req2       = r2;
        stall      = st;
        comnum     = 2'(cn);
        commit_ptr = 6'(cp);
        prmiss     = pm;
        prmiss_ptr = 6'(pp);
        #1;
        free = NUM - m_cnt;
        g1 = rst && r1 && !st && !pm && (m_busy == 0) && (free >= 1);
        g2 = g1 && r2 && (free >= 2);
        s_dp1 = dp1; s_dp2 = dp2; s_a1 = dp1_addr; s_a2 = dp2_addr;
        chk("dp1", 64'(dp1), 64'(g1));
        chk("dp2", 64'(dp2), 64'(g2));
        chk("dp1_addr", 64'(dp1_addr), 64'(m_ptr));
        chk("dp2_addr", 64'(dp2_addr), 64'((m_ptr + 1) % NUM));
        chk("dispatch_ptr", 64'(dispatch_ptr), 64'(m_ptr));
        chk("freenum", 64'(freenum), 64'(free));
        chk("full", 64'(full), 64'(free == 0));
        chk("kill_vec", kill_vec, m_kill);
        chk("busy", 64'(busy), 64'(m_busy > 0));

        n_kill = '0;
        if (!rst) begin
            n_ptr = 0; n_cnt = 0; n_busy = 0;
        end else if (pm) begin
            n_ptr  = (pp + 1) % NUM;
            n_cnt  = ((pp - cp + NUM) % NUM) + 1 - cn;
            n_busy = RC;
            j = (pp + 1) % NUM;
            while (j != m_ptr) begin
                n_kill[j] = 1'b1;
                j = (j + 1) % NUM;
            end
        end else begin
            n_ptr  = (m_ptr + int'(g1) + int'(g2)) % NUM;
            n_cnt  = m_cnt + int'(g1) + int'(g2) - cn;
            n_busy = (m_busy > 0) ? m_busy - 1 : 0;
        end
        @(posedge clk);
        m_ptr = n_ptr; m_cnt = n_cnt; m_busy = n_busy; m_kill = n_kill;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; req1 = 1'b0; req2 = 1'b0; stall = 1'b0; prmiss = 1'b0;
        comnum = '0; commit_ptr = '0; prmiss_ptr = '0;
        @(posedge clk);
        @(negedge clk);
        m_ptr = 0; m_cnt = 0; m_busy = 0; m_kill = '0;

        // Reset state with requests asserted: grants must stay low.
        step(0, 1, 1, 0, 0, 0, 0, 0);
        chk("rst_freenum", 64'(freenum), 64'd64);
        chk("rst_ptr", 64'(dispatch_ptr), 64'd0);

        // Fill with dual grants.
        for (int k = 0; k < 32; k++) begin
            step(1, 1, 1, 0, 0, 0, 0, 0);
            chk("fill_dp2", 64'(s_dp2), 64'd1);
            chk("fill_a1", 64'(s_a1), 64'(2 * k));
            chk("fill_a2", 64'(s_a2), 64'(2 * k + 1));
        end
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_freenum", 64'(freenum), 64'd0);
        step(1, 1, 1, 0, 0, 0, 0, 0);
        chk("full_nogrant", 64'(s_dp1), 64'd0);
        step(1, 1, 1, 1, 0, 0, 0, 0);

        // Partial grant at the wrap point.
        step(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 31; k++) step(1, 1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        chk("c63_ptr", 64'(dispatch_ptr), 64'd63);
        chk("c63_free", 64'(freenum), 64'd1);
        step(1, 1, 1, 0, 0, 0, 0, 0);
        chk("c63_dp1", 64'(s_dp1), 64'd1);
        chk("c63_dp2", 64'(s_dp2), 64'd0);
        chk("c63_a1", 64'(s_a1), 64'd63);
        chk("c63_wrap_ptr", 64'(dispatch_ptr), 64'd0);
        chk("c63_full", 64'(full), 64'd1);

        // Commit from full: frees are invisible until next cycle.
        step(1, 1, 1, 0, 2, 0, 0, 0);
        chk("commit_full_nogrant", 64'(s_dp1), 64'd0);
        step(1, 1, 1, 0, 0, 0, 0, 0);
        chk("commit_next_dp2", 64'(s_dp2), 64'd1);
        chk("commit_next_a2", 64'(s_a2), 64'd1);

        // Build ptr=10, head=60, count=14, then mispredict at 2.
        step(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 37; k++)
            step(1, 1, 1, 0, (k >= 1 && k <= 30) ? 2 : 0, 0, 0, 0);
        chk("pre_miss_ptr", 64'(dispatch_ptr), 64'd10);
        chk("pre_miss_free", 64'(freenum), 64'd50);
        step(1, 1, 0, 0, 1, 60, 1, 2);
        chk("miss_nogrant", 64'(s_dp1), 64'd0);
        chk("miss_ptr", 64'(dispatch_ptr), 64'd3);
        chk("miss_free", 64'(freenum), 64'd58);
        chk("miss_kill", kill_vec, 64'h0000_0000_0000_03F8);
        chk("miss_busy1", 64'(busy), 64'd1);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        chk("rec1_nogrant", 64'(s_dp1), 64'd0);
        chk("miss_busy2", 64'(busy), 64'd1);
        chk("kill_pulse", kill_vec, 64'd0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        chk("rec2_nogrant", 64'(s_dp1), 64'd0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        chk("rec_first_grant", 64'(s_dp1), 64'd1);
        chk("rec_first_addr", 64'(s_a1), 64'd3);

        // Wrapping kill range: ptr=4, branch at 61 (ROB head).
        step(1, 0, 0, 0, 0, 61, 1, 61);
        chk("wrap_kill", kill_vec, 64'hC000_0000_0000_000F);
        chk("wrap_ptr", 64'(dispatch_ptr), 64'd62);
        chk("wrap_free", 64'(freenum), 64'd63);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 1, 1, 0, 0, 0, 0, 0);

        // Second mispredict inside the recovery window.
        step(1, 0, 0, 0, 0, 61, 1, 1);
        chk("m1_kill", kill_vec, 64'h0000_0000_0000_000C);
        step(1, 1, 0, 0, 0, 61, 1, 63);
        chk("m2_kill", kill_vec, 64'h0000_0000_0000_0003);
        chk("m2_free", 64'(freenum), 64'd61);
        chk("m2_busy", 64'(busy), 64'd1);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        chk("m2_still_blocked", 64'(s_dp1), 64'd0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        chk("m2_first_grant", 64'(s_dp1), 64'd1);
        chk("m2_first_addr", 64'(s_a1), 64'd0);

        // Reset in the middle of recovery.
        step(1, 0, 0, 0, 0, 61, 1, 62);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        chk("rst_rec_busy", 64'(busy), 64'd0);
        chk("rst_rec_ptr", 64'(dispatch_ptr), 64'd0);
        chk("rst_rec_free", 64'(freenum), 64'd64);
        step(1, 1, 1, 0, 0, 0, 0, 0);
        chk("rst_rec_grant", 64'(s_dp2), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
